// File: rtl/cpu_bus_capture.sv
// NES CPU bus front end: synchronises and glitch-filters M2, captures
// addr/data/rw with one strobe per M2 high phase, flags vector fetch and idle.
module cpu_bus_capture #(
  parameter int M2_FILT   = 2,
  parameter int LATCH_DLY = 6,
  parameter int IDLE_TO   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_m2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  output logic        m2_q,
  output logic        m2_rise,
  output logic        m2_fall,
  output logic        cpu_we,
  output logic        cpu_oe,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dat,
  output logic        bus_rw,
  output logic        vec_fetch,
  output logic        cpu_idle
);

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    WAIT = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        m2_meta, m2_s;
  logic [2:0]  filt_cnt;
  logic [3:0]  lat_cnt, lat_nxt;
  logic [11:0] idle_cnt;
  logic        flip, rise_nxt, fall_nxt;
  logic        cap;
  logic        vec_flag;

  assign flip = (m2_s != m2_q)
             && (filt_cnt == 3'(M2_FILT - 1));
  assign rise_nxt = flip && m2_s;
  assign fall_nxt = flip && !m2_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta  <= 1'b0;
      m2_s     <= 1'b0;
      m2_q     <= 1'b0;
      filt_cnt <= '0;
      m2_rise  <= 1'b0;
      m2_fall  <= 1'b0;
    end else begin
      m2_meta <= cpu_m2;
      m2_s    <= m2_meta;
      if (m2_s == m2_q) begin
        filt_cnt <= '0;
      end else if (flip) begin
        m2_q     <= m2_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 3'd1;
      end
      m2_rise <= rise_nxt;
      m2_fall <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    cap       = 1'b0;
    unique case (state)
      LOW: begin
        if (m2_rise) begin
          state_nxt = WAIT;
          lat_nxt   = 4'd1;
        end
      end
      WAIT: begin
        if (!m2_q) begin
          state_nxt = LOW;
        end else if (lat_cnt == 4'(LATCH_DLY)) begin
          cap       = 1'b1;
          state_nxt = HIGH;
        end else begin
          lat_nxt = lat_cnt + 4'd1;
        end
      end
      HIGH: begin
        if (m2_fall) state_nxt = LOW;
      end
      default: state_nxt = LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOW;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // $FFFC read arms the flag; only an immediately following $FFFD read fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_dat   <= '0;
      bus_rw    <= 1'b1;
      cpu_we    <= 1'b0;
      cpu_oe    <= 1'b0;
      vec_fetch <= 1'b0;
      vec_flag  <= 1'b0;
    end else begin
      cpu_we    <= cap && !cpu_rw;
      cpu_oe    <= cap && cpu_rw;
      vec_fetch <= cap && cpu_rw && vec_flag
                && (cpu_addr == 16'hFFFD);
      if (cap) begin
        bus_addr <= cpu_addr;
        bus_dat  <= cpu_dat;
        bus_rw   <= cpu_rw;
        vec_flag <= cpu_rw && (cpu_addr == 16'hFFFC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      cpu_idle <= 1'b0;
    end else begin
      if (rise_nxt) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 12'(IDLE_TO)) begin
        idle_cnt <= idle_cnt + 12'd1;
      end
      cpu_idle <= (idle_cnt == 12'(IDLE_TO));
    end
  end

endmodule

// File: tb/tb_cpu_bus_capture.sv
// Scoreboard bench for cpu_bus_capture: random and directed CPU cycles,
// expected captures queued by a cycle-level model, checked by a monitor.
module tb_cpu_bus_capture;

  localparam int M2_FILT   = 2;
  localparam int LATCH_DLY = 6;
  localparam int IDLE_TO   = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dat = '0;
  logic        m2_q, m2_rise, m2_fall;
  logic        cpu_we, cpu_oe;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dat;
  logic        bus_rw, vec_fetch, cpu_idle;

  cpu_bus_capture #(
    .M2_FILT  (M2_FILT),
    .LATCH_DLY(LATCH_DLY),
    .IDLE_TO  (IDLE_TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_m2   (cpu_m2),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .m2_q     (m2_q),
    .m2_rise  (m2_rise),
    .m2_fall  (m2_fall),
    .cpu_we   (cpu_we),
    .cpu_oe   (cpu_oe),
    .bus_addr (bus_addr),
    .bus_dat  (bus_dat),
    .bus_rw   (bus_rw),
    .vec_fetch(vec_fetch),
    .cpu_idle (cpu_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        vec;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   idle_hi = 0;
  int   vec_cnt = 0;
  int   last_rise = 0;
  bit   vflag = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // monitor: pops one expectation per strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m2_rise) begin
        rise_cnt++;
        last_rise = cyc;
      end
      if (m2_fall) fall_cnt++;
      if (cpu_idle) idle_hi++;
      if (vec_fetch) vec_cnt++;
      if (cpu_we || cpu_oe) begin
        chk("we_oe_exclusive", 32'(cpu_we & cpu_oe), 0);
        if (sb.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          e = sb.pop_front();
          chk("strobe_type_oe", 32'(cpu_oe), 32'(e.rw));
          chk("bus_addr", 32'(bus_addr), 32'(e.addr));
          chk("bus_dat", 32'(bus_dat), 32'(e.dat));
          chk("bus_rw", 32'(bus_rw), 32'(e.rw));
          chk("vec_fetch", 32'(vec_fetch), 32'(e.vec));
          chk("strobe_latency", 32'(cyc - last_rise),
              32'(LATCH_DLY + 1));
        end
      end else if (vec_fetch) begin
        fail_now("vec_fetch_without_strobe");
      end
    end
  end

  // model: filtered M2 stays high for `hi` cycles once hi >= M2_FILT;
  // capture needs it still high LATCH_DLY cycles after the rise pulse
  task automatic push_exp(bit rw, logic [15:0] a, logic [7:0] d, int hi);
    exp_t e;
    if (hi >= M2_FILT && hi >= LATCH_DLY + 1) begin
      e.rw   = rw;
      e.addr = a;
      e.dat  = d;
      e.vec  = vflag && rw && (a == 16'hFFFD);
      vflag  = rw && (a == 16'hFFFC);
      sb.push_back(e);
    end
  endtask

  task automatic bus_cycle(bit rw, logic [15:0] a, logic [7:0] d,
                           int hi, int lo);
    push_exp(rw, a, d, hi);
    @(posedge clk);
    #2;
    cpu_rw   = rw;
    cpu_addr = a;
    cpu_dat  = d;
    cpu_m2   = 1'b1;
    repeat (hi) @(posedge clk);
    #2;
    cpu_m2 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic chk_reset_vals(string name);
    chk(name, {m2_q, m2_rise, m2_fall, cpu_we, cpu_oe,
               vec_fetch, cpu_idle, bus_rw, bus_addr, bus_dat},
        {7'b0, 1'b1, 16'h0, 8'h0});
  endtask

  initial begin
    int r0, f0, v0, i0;
    bit got;
    logic [15:0] a;
    #12;
    chk_reset_vals("reset_values");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // idle: M2 held low since reset
    repeat (200) @(negedge clk);
    chk("idle_early", 32'(cpu_idle), 0);
    repeat (100) @(negedge clk);
    chk("idle_asserted", 32'(cpu_idle), 1);

    // default write; idle drops the cycle after m2_rise
    r0 = rise_cnt;
    f0 = fall_cnt;
    push_exp(1'b0, 16'h8000, 8'hA5, 17);
    @(posedge clk);
    #2;
    cpu_rw   = 1'b0;
    cpu_addr = 16'h8000;
    cpu_dat  = 8'hA5;
    cpu_m2   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m2_rise) got = 1'b1;
    end
    if (!got) begin
      fail_now("rise_timeout");
    end else begin
      chk("idle_during_rise", 32'(cpu_idle), 1);
      @(negedge clk);
      chk("idle_after_rise", 32'(cpu_idle), 0);
    end
    repeat (13) @(posedge clk);
    #2 cpu_m2 = 1'b0;
    repeat (8) @(posedge clk);
    chk("write_rise_count", 32'(rise_cnt - r0), 1);
    chk("write_fall_count", 32'(fall_cnt - f0), 1);
    chk("write_drained", 32'(sb.size()), 0);

    // glitches
    r0 = rise_cnt;
    bus_cycle(1'b0, 16'h8001, 8'h11, 1, 8);
    chk("glitch1_rise", 32'(rise_cnt - r0), 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    bus_cycle(1'b0, 16'h8002, 8'h22, 4, 8);
    chk("glitch4_rise", 32'(rise_cnt - r0), 1);
    chk("glitch4_fall", 32'(fall_cnt - f0), 1);

    // vector fetch
    v0 = vec_cnt;
    bus_cycle(1'b1, 16'hFFFC, 8'h00, 10, 8);
    bus_cycle(1'b1, 16'hFFFD, 8'h80, 10, 8);
    chk("vec_pair_count", 32'(vec_cnt - v0), 1);
    v0 = vec_cnt;
    bus_cycle(1'b1, 16'hFFFC, 8'h00, 10, 8);
    bus_cycle(1'b1, 16'h8000, 8'h55, 10, 8);
    bus_cycle(1'b1, 16'hFFFD, 8'h80, 10, 8);
    chk("vec_broken_count", 32'(vec_cnt - v0), 0);

    // reset mid-WAIT
    @(posedge clk);
    #2;
    cpu_rw   = 1'b0;
    cpu_addr = 16'h6000;
    cpu_dat  = 8'h99;
    cpu_m2   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m2_rise) got = 1'b1;
    end
    if (!got) fail_now("reset_rise_timeout");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    vflag = 1'b0;
    #1 chk_reset_vals("reset_mid_wait");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk_reset_vals("reset_release");
    @(posedge clk);
    #2 cpu_m2 = 1'b0;
    repeat (12) @(posedge clk);
    chk("reset_no_strobe", 32'(sb.size()), 0);
    bus_cycle(1'b0, 16'h6000, 8'h3C, 17, 8);
    chk("post_reset_write", 32'(sb.size()), 0);

    // back-to-back 28-clock periods
    i0 = idle_hi;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        bus_cycle(1'b1, 16'hC000, 8'($urandom), 14, 13);
      else
        bus_cycle(1'b0, 16'hE001, 8'h07, 14, 13);
    end
    chk("b2b_no_idle", 32'(idle_hi - i0), 0);

    // random cycles
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 4)
        0: a = 16'hFFFC;
        1: a = 16'hFFFD;
        default: a = 16'($urandom);
      endcase
      bus_cycle(1'($urandom), a, 8'($urandom),
                $urandom_range(1, 20), $urandom_range(3, 12));
    end

    repeat (20) @(posedge clk);
    chk("final_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
